// File: rtl/irq_controller_if.sv
// rtl/irq_controller_if.sv - CPU register bus and interrupt-acknowledge signals of irq_controller
interface irq_controller_if;
    logic       sel;
    logic       wr;
    logic [1:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic       iack;
    logic [7:0] vector;
    logic       vack;

    modport master (
        output sel, wr, addr, wdata, iack,
        input  rdata, vector, vack
    );

    modport slave (
        input  sel, wr, addr, wdata, iack,
        output rdata, vector, vack
    );
endinterface

// File: rtl/irq_controller.sv
// rtl/irq_controller.sv - 8-source edge/level interrupt controller with fixed priority and ack sequencer
// Optional IRQ_CTRL_SYNC_EN adds a 2-flop synchronizer on every irq_in bit.
module irq_controller #(
    parameter int         WIDTH       = 8,
    parameter logic [7:0] VECTOR_BASE = 8'h40
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] irq_in,
    output logic             irq,
    irq_controller_if.slave  bus
);
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_CAPTURE = 2'd1;
    localparam logic [1:0] ST_HOLD    = 2'd2;

    logic [WIDTH-1:0] pending_q, pending_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] mode_q, mode_d;
    logic [WIDTH-1:0] prev_q;
    logic             irq_q;
    logic             iack_q;
    logic             vack_q, vack_d;
    logic [7:0]       vector_q, vector_d;
    logic [1:0]       state_q, state_d;

    logic [WIDTH-1:0] src;
    logic [WIDTH-1:0] masked;
    logic [WIDTH-1:0] hw_set, w1c, w1s, ack_clr;
    logic             active;
    logic [2:0]       win;
    logic             wr_en;
    logic [7:0]       pend8, mask8, mode8;

`ifdef IRQ_CTRL_SYNC_EN
    logic [WIDTH-1:0] sync1_q, sync2_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= irq_in;
            sync2_q <= sync1_q;
        end
    end

    assign src = sync2_q;
`else
    assign src = irq_in;
`endif

    // Highest set index wins, so later loop iterations override earlier ones.
    always_comb begin
        masked = pending_q & mask_q;
        active = |masked;
        win    = 3'd0;
        for (int i = 0; i < WIDTH; i++) begin
            if (masked[i]) win = i[2:0];
        end
    end

    assign wr_en  = bus.sel & bus.wr;
    assign hw_set = (mode_q & src & ~prev_q) | (~mode_q & src);
    assign w1c    = (wr_en && bus.addr == 2'd0) ? bus.wdata[WIDTH-1:0] : '0;
    assign w1s    = (wr_en && bus.addr == 2'd3) ? bus.wdata[WIDTH-1:0] : '0;
    assign mask_d = (wr_en && bus.addr == 2'd1) ? bus.wdata[WIDTH-1:0] : mask_q;
    assign mode_d = (wr_en && bus.addr == 2'd2) ? bus.wdata[WIDTH-1:0] : mode_q;

    always_comb begin
        ack_clr = '0;
        if (state_q == ST_CAPTURE && active && mode_q[win]) ack_clr[win] = 1'b1;
    end

    // Sets are applied after clears so a coincident event is never lost.
    assign pending_d = (pending_q & ~(w1c | ack_clr)) | hw_set | w1s;

    always_comb begin
        state_d  = state_q;
        vack_d   = vack_q;
        vector_d = vector_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.iack && !iack_q) state_d = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                vector_d = active ? (VECTOR_BASE + 8'd1 + {5'd0, win}) : VECTOR_BASE;
                vack_d   = 1'b1;
                state_d  = ST_HOLD;
            end
            ST_HOLD: begin
                if (!bus.iack) begin
                    vack_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                vack_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pending_q <= '0;
            mask_q    <= '0;
            mode_q    <= '0;
            prev_q    <= '0;
            irq_q     <= 1'b0;
            iack_q    <= 1'b0;
            vack_q    <= 1'b0;
            vector_q  <= VECTOR_BASE;
            state_q   <= ST_IDLE;
        end else begin
            pending_q <= pending_d;
            mask_q    <= mask_d;
            mode_q    <= mode_d;
            prev_q    <= src;
            irq_q     <= active;
            iack_q    <= bus.iack;
            vack_q    <= vack_d;
            vector_q  <= vector_d;
            state_q   <= state_d;
        end
    end

    always_comb begin
        pend8 = '0;
        mask8 = '0;
        mode8 = '0;
        pend8[WIDTH-1:0] = pending_q;
        mask8[WIDTH-1:0] = mask_q;
        mode8[WIDTH-1:0] = mode_q;
        case (bus.addr)
            2'd0:    bus.rdata = pend8;
            2'd1:    bus.rdata = mask8;
            2'd2:    bus.rdata = mode8;
            default: bus.rdata = {active, 4'b0000, win};
        endcase
    end

    assign irq        = irq_q;
    assign bus.vack   = vack_q;
    assign bus.vector = vector_q;
endmodule
